// File: rtl/dpi_sram_arb_if.sv
// rtl/dpi_sram_arb_if.sv - master-side request/response and dpi_sram bus bundle for dpi_sram_arb
interface dpi_sram_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = 8
);
   logic              m0_req_valid;
   logic              m0_req_ready;
   logic [ADDR_W-1:0] m0_req_addr;
   logic              m0_req_wen;
   logic [DATA_W-1:0] m0_req_wdata;
   logic [MASK_W-1:0] m0_req_wmask;
   logic              m0_resp_valid;
   logic              m0_resp_ready;
   logic [DATA_W-1:0] m0_resp_rdata;

   logic              m1_req_valid;
   logic              m1_req_ready;
   logic [ADDR_W-1:0] m1_req_addr;
   logic              m1_req_wen;
   logic [DATA_W-1:0] m1_req_wdata;
   logic [MASK_W-1:0] m1_req_wmask;
   logic              m1_resp_valid;
   logic              m1_resp_ready;
   logic [DATA_W-1:0] m1_resp_rdata;

   logic              sram_ena;
   logic              sram_wen;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [MASK_W-1:0] sram_wmask;
   logic [DATA_W-1:0] sram_rdata;

   // Arbiter side: consumes master requests, produces responses, drives the SRAM.
   modport slave (
      input  m0_req_valid, m0_req_addr, m0_req_wen, m0_req_wdata, m0_req_wmask, m0_resp_ready,
      output m0_req_ready, m0_resp_valid, m0_resp_rdata,
      input  m1_req_valid, m1_req_addr, m1_req_wen, m1_req_wdata, m1_req_wmask, m1_resp_ready,
      output m1_req_ready, m1_resp_valid, m1_resp_rdata,
      output sram_ena, sram_wen, sram_addr, sram_wdata, sram_wmask,
      input  sram_rdata
   );

   // Environment side: the two masters plus the SRAM model.
   modport master (
      output m0_req_valid, m0_req_addr, m0_req_wen, m0_req_wdata, m0_req_wmask, m0_resp_ready,
      input  m0_req_ready, m0_resp_valid, m0_resp_rdata,
      output m1_req_valid, m1_req_addr, m1_req_wen, m1_req_wdata, m1_req_wmask, m1_resp_ready,
      input  m1_req_ready, m1_resp_valid, m1_resp_rdata,
      input  sram_ena, sram_wen, sram_addr, sram_wdata, sram_wmask,
      output sram_rdata
   );
endinterface

// File: rtl/dpi_sram_arb.sv
// rtl/dpi_sram_arb.sv - two-master arbiter/sequencer for dpi_sram; define DPI_SRAM_ARB_RR_EN for round-robin
module dpi_sram_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = 8
) (
   input  logic          clock,
   input  logic          resetn,
   dpi_sram_arb_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   logic [1:0]        state;
   logic              owner;
   logic              gnt0;
   logic              gnt1;
   logic              accept;
   logic              owner_ready;
   logic              wen_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [MASK_W-1:0] wmask_q;

`ifdef DPI_SRAM_ARB_RR_EN
   // Last-granted master; on a tie the other master wins.
   logic rr_ptr;

   // Round-robin grant: a lone requester always wins, a tie goes to ~rr_ptr.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (bus.m0_req_valid && bus.m1_req_valid) begin
         gnt1 = ~rr_ptr;
         gnt0 = rr_ptr;
      end else begin
         gnt0 = bus.m0_req_valid;
         gnt1 = bus.m1_req_valid;
      end
   end

   // Remember who was granted at each accept.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         rr_ptr <= 1'b0;
      else if (accept)
         rr_ptr <= gnt1;
   end
`else
   // Fixed priority: the load/store unit (master 1) beats instruction fetch.
   assign gnt1 = bus.m1_req_valid;
   assign gnt0 = bus.m0_req_valid & ~bus.m1_req_valid;
`endif

   assign accept      = (state == S_IDLE) && (gnt0 || gnt1);
   assign owner_ready = owner ? bus.m1_resp_ready : bus.m0_resp_ready;

   assign bus.m0_req_ready  = (state == S_IDLE) && gnt0;
   assign bus.m1_req_ready  = (state == S_IDLE) && gnt1;
   assign bus.m0_resp_valid = (state == S_RESP) && !owner;
   assign bus.m1_resp_valid = (state == S_RESP) && owner;
   // rdata is unqualified on both masters; resp_valid alone marks it meaningful.
   assign bus.m0_resp_rdata = bus.sram_rdata;
   assign bus.m1_resp_rdata = bus.sram_rdata;

   // The SRAM sees exactly one enable cycle per transaction; rdata stays put afterwards.
   assign bus.sram_ena   = (state == S_ISSUE);
   assign bus.sram_wen   = wen_q;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_wdata = wdata_q;
   assign bus.sram_wmask = wmask_q;

   // Sequencer: IDLE accepts, ISSUE strobes the SRAM, RESP waits for the owner.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         owner <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_ISSUE;
                  owner <= gnt1;
               end
            end
            S_ISSUE: state <= S_RESP;
            S_RESP: begin
               if (owner_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Capture the winner's payload at accept; held until the next accept.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (accept) begin
         wen_q   <= gnt1 ? bus.m1_req_wen   : bus.m0_req_wen;
         addr_q  <= gnt1 ? bus.m1_req_addr  : bus.m0_req_addr;
         wdata_q <= gnt1 ? bus.m1_req_wdata : bus.m0_req_wdata;
         wmask_q <= gnt1 ? bus.m1_req_wmask : bus.m0_req_wmask;
      end
   end
endmodule
